// File: rtl/reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reg_pipe_pkg
//
// Shared helpers for the elastic register pipeline:
//   count_width()    - width of the occupancy counter able to hold 0..depth
//   depth_is_legal() - elaboration-time guard; a pipeline needs >= 1 stage
// -----------------------------------------------------------------------------
package reg_pipe_pkg;

  // Number of bits needed to represent every value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // A zero-stage pipeline has no register to hold a word, so it is rejected.
  function automatic bit depth_is_legal(input int depth);
    return depth >= 1;
  endfunction

endpackage : reg_pipe_pkg

// File: rtl/reg_pipe_stage.sv
// -----------------------------------------------------------------------------
// reg_pipe_stage
//
// One slot of the elastic pipeline: a valid bit plus a WIDTH-bit data
// register.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   valid offered by the stage (or producer) upstream
//   in_data    in   data offered by the stage (or producer) upstream
//   down_ready in   the stage (or consumer) downstream can take our word
//   flush      in   synchronous discard of the held word
//   valid      out  this stage holds a word
//   data       out  the held word
//   up_ready   out  this stage will take in_valid/in_data at the next edge
//
// Load/hold rule: when up_ready is high the valid bit follows in_valid, but
// the data register only loads on a real word; a bubble leaves the data
// untouched so the register does not toggle for nothing. Flush clears the
// valid bit and keeps the data.
// -----------------------------------------------------------------------------
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             down_ready,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             up_ready
);

  // An empty slot always accepts, even when everything downstream is
  // stalled; this is what collapses bubbles.
  assign up_ready = ~valid | down_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule : reg_pipe_stage

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
//
// Parametrised elastic register pipeline: WIDTH-bit words move through DEPTH
// register stages with backpressure, bubble collapsing, a synchronous flush
// and a registered occupancy count.
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      number of register stages (>= 1)
//   RESET_DATA value loaded into every stage data register on reset
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   s_valid  in   upstream word valid
//   s_ready  out  pipeline accepts a word this cycle
//   s_data   in   upstream word
//   m_valid  out  output stage holds a valid word (registered)
//   m_ready  in   downstream accepts the word this cycle
//   m_data   out  output stage word (registered)
//   flush    in   synchronous discard of every held word
//   count    out  number of valid stages, 0..DEPTH (registered)
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. valid never depends on ready; once a producer
// raises valid it keeps valid and data stable until the transfer happens.
// s_ready is combinational from m_ready through the ready chain, so a full
// pipeline still accepts a word in the same cycle it delivers one.
// -----------------------------------------------------------------------------
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int              CW         = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam bit DEPTH_OK = depth_is_legal(DEPTH);

  if (!DEPTH_OK) begin : g_depth_check
    $error("reg_pipe: DEPTH must be at least 1");
  end

  // rdy[i] is the ready seen by stage i-1 (rdy[0] faces the producer and
  // rdy[DEPTH] is the consumer's m_ready). Kept as an unpacked array so each
  // link of the chain is its own signal.
  logic             rdy [DEPTH+1];
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d   [DEPTH];

  assign rdy[DEPTH] = m_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             in_v;
    logic [WIDTH-1:0] in_d;

    if (i == 0) begin : g_head
      // Nothing is admitted while flushing.
      assign in_v = s_valid & ~flush;
      assign in_d = s_data;
    end else begin : g_body
      assign in_v = v[i-1];
      assign in_d = d[i-1];
    end

    reg_pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_v),
      .in_data    (in_d),
      .down_ready (rdy[i+1]),
      .flush      (flush),
      .valid      (v[i]),
      .data       (d[i]),
      .up_ready   (rdy[i])
    );
  end

  assign s_ready = rdy[0] & ~flush;
  assign m_valid = v[DEPTH-1];
  assign m_data  = d[DEPTH-1];

  // Occupancy: one word in and one word out in the same cycle leaves the
  // count unchanged. An output transfer during flush still counts as
  // delivered, but the flush empties every stage so the result is 0 anyway.
  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] count_next;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // The registered count and the number of set valid bits are updated on
  // the same edge, so they must always agree.
  a_count_bound : assert property (
    @(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH)
  );

  a_count_matches_valid : assert property (
    @(posedge clk) disable iff (!rst_n) count == CW'($countones(v))
  );

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_pipe
//
// Directed bench for reg_pipe. Three instances:
//   a: WIDTH=8,  DEPTH=4  (main scenarios)
//   b: WIDTH=1,  DEPTH=1  (registered flip-flop with handshake)
//   c: WIDTH=32, DEPTH=7
// Inputs are driven at the falling edge and outputs sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_pipe;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT a
  logic       a_s_valid = 1'b0, a_s_ready, a_m_valid, a_m_ready = 1'b0, a_flush = 1'b0;
  logic [7:0] a_s_data = '0, a_m_data;
  logic [2:0] a_count;

  reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_DATA(8'h00)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .flush(a_flush), .count(a_count)
  );

  // ---------------------------------------------------------------- DUT b
  logic       b_s_valid = 1'b0, b_s_ready, b_m_valid, b_m_ready = 1'b0, b_flush = 1'b0;
  logic [0:0] b_s_data = '0, b_m_data;
  logic [0:0] b_count;

  reg_pipe #(.WIDTH(1), .DEPTH(1), .RESET_DATA(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .flush(b_flush), .count(b_count)
  );

  // ---------------------------------------------------------------- DUT c
  logic        c_s_valid = 1'b0, c_s_ready, c_m_valid, c_m_ready = 1'b0, c_flush = 1'b0;
  logic [31:0] c_s_data = '0, c_m_data;
  logic [2:0]  c_count;

  reg_pipe #(.WIDTH(32), .DEPTH(7), .RESET_DATA(32'h0)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .flush(c_flush), .count(c_count)
  );

  // ---------------------------------------------------------------- bookkeeping
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input int sel, input logic vld, input logic [31:0] dat,
                       input logic mrdy);
    case (sel)
      0: begin a_s_valid = vld; a_s_data = dat[7:0]; a_m_ready = mrdy; end
      1: begin b_s_valid = vld; b_s_data = dat[0:0]; b_m_ready = mrdy; end
      default: begin c_s_valid = vld; c_s_data = dat; c_m_ready = mrdy; end
    endcase
  endtask

  task automatic sample(input int sel, output logic srdy, output logic mvld,
                        output logic [31:0] mdat, output logic [31:0] cnt);
    case (sel)
      0: begin srdy = a_s_ready; mvld = a_m_valid; mdat = {24'b0, a_m_data}; cnt = {29'b0, a_count}; end
      1: begin srdy = b_s_ready; mvld = b_m_valid; mdat = {31'b0, b_m_data}; cnt = {31'b0, b_count}; end
      default: begin srdy = c_s_ready; mvld = c_m_valid; mdat = c_m_data; cnt = {29'b0, c_count}; end
    endcase
  endtask

  function automatic logic [31:0] stream_word(input int k, input logic [31:0] mask);
    logic [31:0] kk;
    kk = k + 1;
    return (32'h1000_0001 * kk) & mask;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_cnt++; if (a_m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_m_data !== 8'h00) $display("FAIL reset_m_data: got %h expected 00", a_m_data); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", a_count); else pass_cnt++;
    chk_cnt++; if (c_m_valid !== 1'b0) $display("FAIL reset_c_m_valid: got %b expected 0", c_m_valid); else pass_cnt++;
    rst_n = 1'b1;
    a_s_valid = 1'b0;
    a_s_data  = 8'h00;
    #1;
    chk_cnt++; if (a_s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", a_s_ready); else pass_cnt++;
  endtask

  // Continuous push of n words with m_ready held high. Word k is accepted at
  // edge k and shows on the outputs in sample cycle k+depth.
  task automatic test_stream(input int sel, input int depth, input int n,
                             input logic [31:0] mask);
    logic srdy, mvld;
    logic [31:0] mdat, cnt, exp_cnt, exp_dat;
    int acc, del;
    for (int c = 0; c <= depth + n; c++) begin
      @(negedge clk);
      drive(sel, c < n, (c < n) ? stream_word(c, mask) : 32'h0, 1'b1);
      #1;
      sample(sel, srdy, mvld, mdat, cnt);
      chk_cnt++; if (srdy !== 1'b1) $display("FAIL stream%0d_s_ready c=%0d: got %b expected 1", sel, c, srdy); else pass_cnt++;
      if (c >= depth && c < depth + n) begin
        exp_dat = stream_word(c - depth, mask);
        chk_cnt++; if (mvld !== 1'b1) $display("FAIL stream%0d_m_valid c=%0d: got %b expected 1", sel, c, mvld); else pass_cnt++;
        chk_cnt++; if (mdat !== exp_dat) $display("FAIL stream%0d_m_data c=%0d: got %h expected %h", sel, c, mdat, exp_dat); else pass_cnt++;
      end else begin
        chk_cnt++; if (mvld !== 1'b0) $display("FAIL stream%0d_m_valid c=%0d: got %b expected 0", sel, c, mvld); else pass_cnt++;
      end
      acc = (c < n) ? c : n;
      del = ((c < depth + n) ? c : depth + n) - depth;
      if (del < 0) del = 0;
      exp_cnt = acc - del;
      chk_cnt++; if (cnt !== exp_cnt) $display("FAIL stream%0d_count c=%0d: got %0d expected %0d", sel, c, cnt, exp_cnt); else pass_cnt++;
    end
    @(negedge clk);
    drive(sel, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    int next_in = 1;
    logic [31:0] exp_w;
    exp_q.delete();
    for (int k = 1; k <= 6; k++) exp_q.push_back(k);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a_s_valid = (next_in <= 6);
      a_s_data  = 8'(next_in);
      a_m_ready = (c >= 6);
      #1;
      if (c < 4) begin
        chk_cnt++; if (a_s_ready !== 1'b1) $display("FAIL bp_s_ready_fill c=%0d: got %b expected 1", c, a_s_ready); else pass_cnt++;
      end
      if (c == 4 || c == 5) begin
        chk_cnt++; if (a_s_ready !== 1'b0) $display("FAIL bp_s_ready_full c=%0d: got %b expected 0", c, a_s_ready); else pass_cnt++;
        chk_cnt++; if (a_count !== 3'd4) $display("FAIL bp_count_full c=%0d: got %0d expected 4", c, a_count); else pass_cnt++;
      end
      if (a_s_valid && a_s_ready) next_in++;
      if (a_m_valid && a_m_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL bp_extra_word: got %h expected none", a_m_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk_cnt++; if ({24'b0, a_m_data} !== exp_w) $display("FAIL bp_order: got %h expected %h", a_m_data, exp_w); else pass_cnt++;
        end
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL bp_lost_words: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (next_in != 7) $display("FAIL bp_accepted: got %0d expected 6", next_in - 1); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd0) $display("FAIL bp_count_drained: got %0d expected 0", a_count); else pass_cnt++;
    @(negedge clk);
    a_s_valid = 1'b0; a_m_ready = 1'b0;
  endtask

  task automatic test_bubble_collapse();
    // cycle: 0 push 11, 1-2 idle, 3 push 22, 4-6 idle with m_ready low
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_m_ready = 1'b0;
      a_s_valid = (c == 0 || c == 3);
      a_s_data  = (c == 0) ? 8'h11 : (c == 3) ? 8'h22 : 8'h00;
      #1;
    end
    chk_cnt++; if (a_count !== 3'd2) $display("FAIL bubble_count: got %0d expected 2", a_count); else pass_cnt++;
    chk_cnt++; if (a_s_ready !== 1'b1) $display("FAIL bubble_s_ready: got %b expected 1", a_s_ready); else pass_cnt++;
    chk_cnt++; if (a_m_valid !== 1'b1) $display("FAIL bubble_m_valid: got %b expected 1", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_m_data !== 8'h11) $display("FAIL bubble_head: got %h expected 11", a_m_data); else pass_cnt++;
    @(negedge clk);
    a_m_ready = 1'b1;
    #1;
    chk_cnt++; if (a_m_data !== 8'h11) $display("FAIL bubble_first_out: got %h expected 11", a_m_data); else pass_cnt++;
    @(negedge clk);
    #1;
    // 22 was sitting right behind the head, so it is presented next cycle.
    chk_cnt++; if (a_m_valid !== 1'b1) $display("FAIL bubble_second_valid: got %b expected 1", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_m_data !== 8'h22) $display("FAIL bubble_second_out: got %h expected 22", a_m_data); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (a_m_valid !== 1'b0) $display("FAIL bubble_empty_valid: got %b expected 0", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd0) $display("FAIL bubble_empty_count: got %0d expected 0", a_count); else pass_cnt++;
    a_m_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_m_ready = 1'b0;
      a_s_valid = 1'b1;
      a_s_data  = 8'h31 + 8'(c);
    end
    @(negedge clk);
    a_flush   = 1'b1;
    a_s_valid = 1'b1;
    a_s_data  = 8'h44;
    #1;
    chk_cnt++; if (a_s_ready !== 1'b0) $display("FAIL flush_s_ready: got %b expected 0", a_s_ready); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd3) $display("FAIL flush_count_before: got %0d expected 3", a_count); else pass_cnt++;
    @(negedge clk);
    a_flush   = 1'b0;
    a_s_valid = 1'b0;
    a_m_ready = 1'b1;
    #1;
    chk_cnt++; if (a_m_valid !== 1'b0) $display("FAIL flush_m_valid: got %b expected 0", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd0) $display("FAIL flush_count_after: got %0d expected 0", a_count); else pass_cnt++;
    // Neither the flushed words nor the one offered during flush may emerge.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk_cnt++; if (a_m_valid !== 1'b0) $display("FAIL flush_no_output c=%0d: got %b expected 0 (data %h)", c, a_m_valid, a_m_data); else pass_cnt++;
    end
    a_m_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_m_ready = 1'b0;
      a_s_valid = 1'b1;
      a_s_data  = 8'h51 + 8'(c);
    end
    @(negedge clk);
    a_s_data = 8'h55;
    #1;
    chk_cnt++; if (a_count !== 3'd4) $display("FAIL midrst_full_count: got %0d expected 4", a_count); else pass_cnt++;
    chk_cnt++; if (a_s_ready !== 1'b0) $display("FAIL midrst_full_s_ready: got %b expected 0", a_s_ready); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_s_valid = 1'b0;
    #1;
    chk_cnt++; if (a_m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b expected 0", a_m_valid); else pass_cnt++;
    chk_cnt++; if (a_m_data !== 8'h00) $display("FAIL midrst_m_data: got %h expected 00", a_m_data); else pass_cnt++;
    chk_cnt++; if (a_count !== 3'd0) $display("FAIL midrst_count: got %0d expected 0", a_count); else pass_cnt++;
    chk_cnt++; if (a_s_ready !== 1'b1) $display("FAIL midrst_s_ready: got %b expected 1", a_s_ready); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_stream(0, 4, 8, 32'h0000_00FF);
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_mid_reset();
    test_stream(1, 1, 6, 32'h0000_0001);
    test_stream(2, 7, 10, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_reg_pipe
